// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file, 2 write ports, write-first bypass, busy scoreboard, clear sequencer
// Optional feature macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero)
module regfile_mp_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     init_done
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0]   NREGS_W  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                     state_q;
    logic [ADDR_W-1:0]          clr_idx_q;
    logic                       init_done_q;
    logic [DATA_W-1:0]          mem_q [NUM_REGS];
    logic [NUM_REGS-1:0]        busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]          rd_valid_q, rd_valid_d;
    logic [NUM_RD-1:0]          rd_busy_q, rd_busy_d;
    logic                       run;
    logic                       wr0_hit, wr1_hit, alloc_hit;
    logic [ADDR_W-1:0]          ra [NUM_RD];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_EN && (a == '0);
    endfunction

    assign run       = (state_q == S_RUN);
    assign wr0_hit   = run && wr0_en && in_range(wr0_addr) && !is_zero(wr0_addr);
    assign wr1_hit   = run && wr1_en && in_range(wr1_addr) && !is_zero(wr1_addr);
    assign alloc_hit = run && alloc_en && in_range(alloc_addr) && !is_zero(alloc_addr);

    // Alloc is applied last so it overrides a same-cycle write clear.
    always_comb begin
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        rd_busy_d  = rd_busy_q;
        rd_valid_d = '0;
        if (wr0_hit)   busy_d[wr0_addr]   = 1'b0;
        if (wr1_hit)   busy_d[wr1_addr]   = 1'b0;
        if (alloc_hit) busy_d[alloc_addr] = 1'b1;
        for (int k = 0; k < NUM_RD; k++) begin
            ra[k] = rd_addr[k*ADDR_W +: ADDR_W];
            if (run && rd_en[k]) begin
                rd_valid_d[k] = 1'b1;
                if (!in_range(ra[k]) || is_zero(ra[k])) begin
                    rd_data_d[k*DATA_W +: DATA_W] = '0;
                    rd_busy_d[k]                  = 1'b0;
                end else begin
                    if (wr1_hit && wr1_addr == ra[k])
                        rd_data_d[k*DATA_W +: DATA_W] = wr1_data;
                    else if (wr0_hit && wr0_addr == ra[k])
                        rd_data_d[k*DATA_W +: DATA_W] = wr0_data;
                    else
                        rd_data_d[k*DATA_W +: DATA_W] = mem_q[ra[k]];
                    rd_busy_d[k] = busy_d[ra[k]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            clr_idx_q   <= '0;
            init_done_q <= 1'b0;
            busy_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= '0;
            rd_busy_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_busy_q  <= rd_busy_d;
            if (state_q == S_INIT) begin
                clr_idx_q <= clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_q     <= S_RUN;
                    init_done_q <= 1'b1;
                end
            end
        end
    end

    // Storage has no reset: the INIT sweep zeroes it; port 1 is written last so it wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_INIT) begin
                mem_q[clr_idx_q] <= '0;
            end else begin
                if (wr0_hit) mem_q[wr0_addr] <= wr0_data;
                if (wr1_hit) mem_q[wr1_addr] <= wr1_data;
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_busy   = rd_busy_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;
    logic         clk = 1'b0;
    logic         reset;
    logic         wr0_en, wr1_en, alloc_en;
    logic [4:0]   wr0_addr, wr1_addr, alloc_addr;
    logic [63:0]  wr0_data, wr1_data;
    logic [1:0]   rd_en;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_valid;
    logic [1:0]   rd_busy;
    logic         init_done;

    int total = 0;
    int bad   = 0;

    regfile_mp_sb dut (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_busy(rd_busy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        alloc_en = 0; alloc_addr = 0;
        rd_en = 0; rd_addr = 0;
    endtask

    task automatic read2(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        rd_en = en;
        rd_addr = {a1, a0};
    endtask

    // Waits for init_done after a reset pulse; returns cycles counted after reset release.
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        total++;
        if (init_done !== 1'b0 || rd_valid !== 2'b00 || rd_busy !== 2'b00 || rd_data !== 128'h0) begin
            bad++;
            $display("FAIL reset_state: init_done=%b valid=%b busy=%b data=%h want 0/00/00/0",
                     init_done, rd_valid, rd_busy, rd_data);
        end
        read2(2'b11, 5'd1, 5'd2);
        wr0_en = 1; wr0_addr = 5'd1; wr0_data = 64'h99;
        alloc_en = 1; alloc_addr = 5'd2;
        for (int i = 1; i <= 32; i++) begin
            tick();
            total++;
            if (init_done !== (i >= 32) || rd_valid !== 2'b00) begin
                bad++;
                $display("FAIL init_seq cycle %0d: init_done=%b valid=%b want %b/00",
                         i, init_done, rd_valid, (i >= 32));
            end
        end
        idle();
        read2(2'b11, 5'd1, 5'd31);
        tick();
        total++;
        if (rd_valid !== 2'b11 || rd_data !== 128'h0 || rd_busy !== 2'b00) begin
            bad++;
            $display("FAIL post_init_read: valid=%b busy=%b data=%h want 11/00/0",
                     rd_valid, rd_busy, rd_data);
        end
        idle();
        tick();
        total++;
        if (rd_valid !== 2'b00) begin
            bad++;
            $display("FAIL valid_pulse: valid=%b want 00", rd_valid);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 64'hDEAD_BEEF;
        read2(2'b01, 5'd5, 5'd0);
        tick();
        total++;
        if (rd_data[63:0] !== 64'hDEAD_BEEF || rd_valid !== 2'b01) begin
            bad++;
            $display("FAIL bypass_wr0: data=%h valid=%b want deadbeef/01", rd_data[63:0], rd_valid);
        end
        idle();
        read2(2'b10, 5'd0, 5'd5);
        tick();
        total++;
        if (rd_data[127:64] !== 64'hDEAD_BEEF || rd_valid !== 2'b10) begin
            bad++;
            $display("FAIL readback_5: data=%h valid=%b want deadbeef/10", rd_data[127:64], rd_valid);
        end
        idle();
        tick();
        total++;
        if (rd_data[127:64] !== 64'hDEAD_BEEF) begin
            bad++;
            $display("FAIL data_hold: data=%h want deadbeef", rd_data[127:64]);
        end
    endtask

    task automatic test_dual_write();
        idle();
        wr0_en = 1; wr0_addr = 5'd7; wr0_data = 64'h11;
        wr1_en = 1; wr1_addr = 5'd7; wr1_data = 64'h22;
        read2(2'b11, 5'd7, 5'd7);
        tick();
        total++;
        if (rd_data !== {64'h22, 64'h22}) begin
            bad++;
            $display("FAIL dual_write_bypass: data=%h want both 22", rd_data);
        end
        idle();
        read2(2'b11, 5'd7, 5'd7);
        tick();
        total++;
        if (rd_data !== {64'h22, 64'h22}) begin
            bad++;
            $display("FAIL dual_write_store: data=%h want both 22", rd_data);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        alloc_en = 1; alloc_addr = 5'd3;
        tick();
        idle();
        read2(2'b01, 5'd3, 5'd0);
        tick();
        total++;
        if (rd_busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL busy_set: busy=%b want 1", rd_busy[0]);
        end
        idle();
        wr1_en = 1; wr1_addr = 5'd3; wr1_data = 64'h5;
        read2(2'b01, 5'd3, 5'd0);
        tick();
        total++;
        if (rd_busy[0] !== 1'b0 || rd_data[63:0] !== 64'h5) begin
            bad++;
            $display("FAIL busy_clear: busy=%b data=%h want 0/5", rd_busy[0], rd_data[63:0]);
        end
        idle();
        alloc_en = 1; alloc_addr = 5'd9;
        wr0_en = 1; wr0_addr = 5'd9; wr0_data = 64'h1;
        read2(2'b10, 5'd0, 5'd9);
        tick();
        total++;
        if (rd_busy[1] !== 1'b1 || rd_data[127:64] !== 64'h1) begin
            bad++;
            $display("FAIL alloc_wins_same_cycle: busy=%b data=%h want 1/1", rd_busy[1], rd_data[127:64]);
        end
        idle();
        read2(2'b11, 5'd9, 5'd3);
        tick();
        total++;
        if (rd_busy !== 2'b01 || rd_data[63:0] !== 64'h1) begin
            bad++;
            $display("FAIL busy_persist: busy=%b data0=%h want 01/1", rd_busy, rd_data[63:0]);
        end
    endtask

    task automatic test_reset_mid_init();
        int cyc;
        idle();
        wr0_en = 1; wr0_addr = 5'd4; wr0_data = 64'hAA;
        tick();
        idle();
        read2(2'b01, 5'd4, 5'd0);
        tick();
        total++;
        if (rd_data[63:0] !== 64'hAA) begin
            bad++;
            $display("FAIL pre_reset_write: data=%h want aa", rd_data[63:0]);
        end
        idle();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1;
        tick();
        reset = 0;
        wait_init(cyc);
        total++;
        if (cyc !== 32 || init_done !== 1'b1) begin
            bad++;
            $display("FAIL reinit_latency: cycles=%0d init_done=%b want 32/1", cyc, init_done);
        end
        read2(2'b11, 5'd4, 5'd9);
        tick();
        total++;
        if (rd_data !== 128'h0 || rd_valid !== 2'b11 || rd_busy !== 2'b00) begin
            bad++;
            $display("FAIL cleared_after_reset: data=%h valid=%b busy=%b want 0/11/00",
                     rd_data, rd_valid, rd_busy);
        end
    endtask

    task automatic test_zero_reg();
        logic [63:0] exp_data;
`ifdef REGFILE_ZERO_REG_EN
        exp_data = 64'h0;
`else
        exp_data = 64'hFF;
`endif
        idle();
        alloc_en = 1; alloc_addr = 5'd0;
        tick();
        idle();
        wr0_en = 1; wr0_addr = 5'd0; wr0_data = 64'hFF;
        tick();
        idle();
        read2(2'b01, 5'd0, 5'd0);
        tick();
        total++;
        if (rd_data[63:0] !== exp_data || rd_busy[0] !== 1'b0 || rd_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL zero_reg: data=%h busy=%b valid=%b want %h/0/1",
                     rd_data[63:0], rd_busy[0], rd_valid[0], exp_data);
        end
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_reset_mid_init();
        test_zero_reg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file, successor to the 2R/1W file: NUM_RD read ports, 2 write ports, write-first bypass, per-register busy scoreboard, and a hardware clear sequencer after reset.
- Sits between decode (reads, busy allocation) and writeback (two retire ports) in the datapath.
- Reads are registered with 1-cycle latency; all logic is on clk posedge (no negedge writes).

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width
- NUM_REGS, 32, number of registers (≤ 2**ADDR_W)
- NUM_RD, 2, number of read ports (1..8)

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  flattened read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  flattened registered read data
- rd_valid  out  NUM_RD  per-port 1-cycle pulse, data valid
- rd_busy  out  NUM_RD  busy bit of the addressed register, aligned with rd_data
- alloc_en  in  1  mark a register pending (busy)
- alloc_addr  in  ADDR_W  register to mark
- init_done  out  1  high once clear sequence has finished

Behaviour:
- Reset values: rd_data=0, rd_valid=0, rd_busy=0, init_done=0, all busy bits=0, FSM=INIT, clr_idx=0.
- FSM INIT: each cycle writes 0 to reg[clr_idx] and increments clr_idx; at clr_idx==NUM_REGS-1 go to RUN next cycle. init_done=1 from the first RUN cycle, i.e. NUM_REGS cycles after reset deasserts. In INIT, wr*/alloc/rd_en are ignored and rd_valid stays 0.
- FSM RUN: stays in RUN until reset. Reset asserted in any state (including mid-INIT) restarts INIT from clr_idx=0 and clears all busy bits.
- Write: wrN_en with addr<NUM_REGS updates reg on the posedge. If both ports target the same address in one cycle, port 1 wins. Addresses ≥NUM_REGS are ignored.
- Read: rd_en[k] sampled at posedge T; rd_data/rd_valid/rd_busy for port k are presented after T (valid during cycle T+1). rd_valid[k]=0 when rd_en[k]=0. rd_data holds its last value when not reading.
- Bypass (write-first): a read whose address matches a same-cycle write returns the written data. If both write ports match, wr1_data is returned.
- Out-of-range read address returns data 0 and busy 0, with rd_valid still 1.
- Scoreboard: alloc_en sets busy[alloc_addr]. Any wrN_en clears busy[wrN_addr]. If alloc and a write hit the same address in one cycle, alloc wins and busy stays 1.
- rd_busy reports the post-update busy state for that cycle (same-cycle write clear and alloc set both visible).
- Combinational cost: NUM_RD independent read muxes with bypass compare; no read-to-read interaction.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: reg[0] is hardwired to zero. Writes to address 0 are dropped and do not clear busy. Alloc to address 0 is ignored. Reads of address 0 return 0 with rd_busy=0, with no bypass.
- Undefined: address 0 behaves as a general register.

Test Plan:
- Reset, then idle with defaults: init_done=0 for 32 cycles, rises on cycle 32. A read of any address after that returns 0, rd_valid=1 for one cycle.
- wr0_en addr=5 data=0xDEAD_BEEF, with rd_en[0] addr=5 in the same cycle: next cycle rd_data[0]=0xDEAD_BEEF (bypass). A later read of 5 returns the same value.
- wr0 addr=7 data=0x11 and wr1 addr=7 data=0x22 in the same cycle, plus a read of 7 on ports 0 and 1: both return 0x22. A subsequent read also returns 0x22.
- alloc addr=3, then read 3: rd_busy[0]=1. Then wr1 addr=3 data=0x5 with a same-cycle read: rd_busy=0, rd_data=0x5. Alloc and write to addr 9 in one cycle: busy stays 1.
- Write addr=4 data=0xAA, then assert reset for 1 cycle at INIT step 10 after a second reset. Reads after init_done return 0 for addr 4, and init_done arrives 32 cycles after the last reset.
- With REGFILE_ZERO_REG_EN: write addr 0 data=0xFF plus alloc 0, then read 0 → rd_data=0, rd_busy=0. Without the macro the same sequence → rd_data=0xFF, rd_busy=0.
